// File: rtl/uart_tx_en_pkg.sv
// Shared types, constants and helpers for the enable-driven UART transmitter.
package uart_tx_en_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic ONE   = 1'b1;
    localparam logic ZERO  = 1'b0;

    // Smallest r such that 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_en_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module fifo_sync
    import uart_tx_en_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned CNT_W = DEPTH_BITS + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy tracking; pointers wrap naturally modulo depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_en.sv
// 8N1 UART transmitter stepped by an external baud-rate enable pulse.
module uart_tx_en
    import uart_tx_en_pkg::*;
#(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned FIFO_DEPTH_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IDX_W = clog2(DATA_BITS + 1);
    localparam int unsigned CNT_W = FIFO_DEPTH_BITS + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_bit_idx_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 w_pop;
    logic                 w_push;
    logic [DATA_BITS-1:0] w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_empty;

    assign w_push    = valid_in & ~w_full;
    assign ready_out = ~w_full;
    assign tx        = r_tx;
    assign busy      = (r_state != IDLE) || (w_count != '0);

    fifo_sync #(
        .WIDTH      (DATA_BITS),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Frame state, shift register and line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= ONE;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Next-state logic; everything holds unless baud_en is high.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = r_tx;
        w_pop         = FALSE;
        if (baud_en) begin
            case (r_state)
                IDLE: begin
                    w_tx_nxt = ONE;
                    if (!w_empty) begin
                        w_pop       = TRUE;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = ZERO;
                        w_state_nxt = START;
                    end
                end
                START: begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_idx_nxt = IDX_W'(1);
                    w_state_nxt   = DATA;
                end
                DATA: begin
                    if (r_bit_idx == IDX_W'(DATA_BITS)) begin
                        w_tx_nxt    = ONE;
                        w_state_nxt = STOP;
                    end else begin
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end
                STOP: begin
                    if (!w_empty) begin
                        w_pop       = TRUE;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = ZERO;
                        w_state_nxt = START;
                    end else begin
                        w_tx_nxt    = ONE;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_tx_nxt    = ONE;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_en.md
Name: uart_tx_en

Overview:
- UART transmitter consuming the fractional clock-enable pulse; the enable runs at the baud rate (one pulse per bit period).
- Buffers bytes in a small synchronous FIFO and serialises them as 8N1 frames.
- Sits downstream of the fractional enable generator and upstream of the FPGA TX pin / debug-log path.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- FIFO_DEPTH_BITS, 4, log2 of FIFO depth (default depth 16).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_en  input  1  one-cycle pulse per bit period, from the fractional enable generator.
- data_in  input  DATA_BITS  byte to transmit.
- valid_in  input  1  data_in valid.
- ready_out  output  1  FIFO can accept; equals not-full.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (reset=1 at a clk edge):
  - FIFO emptied; count=0.
  - ready_out=1, tx=1, busy=0, state=IDLE.
  - A frame in progress is aborted immediately; tx returns high on that same edge.
- Input handshake: a byte is pushed at a clk edge where valid_in=1 and ready_out=1. Otherwise data_in is ignored; a push while full is dropped, and ready_out=0 forbids it.
- Push and pop on the same edge: count is unchanged and ready_out is unchanged.
- ready_out is combinational from count (count != 2^FIFO_DEPTH_BITS). The count width is FIFO_DEPTH_BITS+1.
- State machine advances only on edges with baud_en=1. With baud_en=0, state, bit index and tx hold.
  - IDLE: tx=1. If baud_en and FIFO non-empty: pop head into shift register, tx<=0, go to START.
  - START: on baud_en, tx<=shift[0], shift right, bit_idx<=1, go to DATA.
  - DATA: on baud_en, if bit_idx==DATA_BITS then tx<=1 and go to STOP; else tx<=shift[0], shift right, bit_idx++.
  - STOP: on baud_en, if FIFO non-empty, pop and tx<=0 and go to START (back-to-back frames, no idle gap); else go to IDLE with tx held at 1.
- Frame length is exactly 1+DATA_BITS+1 baud_en periods.
- Each line level lasts from one baud_en edge to the next.
- Latency: a byte pushed at edge N into an empty idle block starts its start bit at the first baud_en edge strictly after N. A push and a baud_en on the same edge does not pop that byte.
- busy = (state!=IDLE) or (count!=0).
- bit_idx width is clog2(DATA_BITS+1). The FIFO read/write pointers wrap modulo depth.
- baud_en asserted every cycle is legal: one bit per clk.

Decomposition:
- Shared package:
  - state encodings (IDLE, START, DATA, STOP);
  - TRUE/FALSE and ONE/ZERO constants;
  - clog2 function.
- Sub-module fifo_sync, parameterised by width and depth bits:
  - ports: push/pop/din/dout/count/full/empty;
  - dout is the head word, combinational (first-word-fall-through);
  - simultaneous push/pop supported, including on empty when push and pop are both gated by non-empty at the start of the edge.
- uart_tx_en holds the FSM, shift register and tx register.

Test Plan:
- Push 0xA5 with baud_en every 4 clks → tx shows 0,1,0,1,0,0,1,0,1,1, each level held 4 clks; busy falls after the stop bit.
- Push 0x00, 0xFF, 0x55 back-to-back, baud_en every 3 clks → three contiguous 10-bit frames with no idle bit between them; a start bit immediately follows each stop bit.
- Push 17 bytes with baud_en=0 → ready_out drops after the 16th push and the 17th is not accepted. Then enable baud_en every clk → 16 frames in push order, and ready_out reasserts on the first pop.
- Push 0x3C, pulse reset=1 for one clk during DATA bit 4 → tx=1, busy=0, ready_out=1 next cycle; subsequent push of 0x81 transmits a clean frame.
- Push 0x81, drive baud_en from the fractional generator with mul=3, div=7 → bit widths of 2 or 3 clks, and exactly 10 baud_en pulses per frame.
- Push and pop on the same edge with the FIFO holding 1 byte → count stays 1, and the byte order on tx is preserved.
